mdu_unit: RTL and testbench
===========================

# mdu_unit

Multi-cycle multiply/divide unit in the EX stage, beside the ALU. It consumes the same forwarded operands `A`/`B` and owns the architectural HI/LO registers. It serves mult/multu/div/divu/mfhi/mflo/mthi/mtlo. It exposes `Busy` so the hazard unit can stall any following MD instruction, and `Cancel` so an exception or interrupt taken in M suppresses a just-issued MD operation.

## Interface
- `MULT_CYCLES`, 5, Busy duration for mult/multu (≥1)
- `DIV_CYCLES`, 10, Busy duration for div/divu (≥1)

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `A`  in  32  rs operand (forwarded)
- `B`  in  32  rt operand (forwarded)
- `MDOp`  in  4  operation code (see Structure)
- `Start`  in  1  EX holds a valid MD instruction this cycle
- `Cancel`  in  1  exception/interrupt flush; gates Start this cycle
- `Busy`  out  1  registered; operation in flight
- `HI`  out  32  architectural HI
- `LO`  out  32  architectural LO
- `Result`  out  32  combinational: HI for mfhi, LO for mflo, else 0

## Operation
- Issue condition: `Start & ~Cancel & ~Busy`. Start while Busy is ignored (hazard unit guarantees it does not happen; bench checks it is harmless).
- mult/multu: 64-bit signed/unsigned product latched into pending {hi,lo}; counter loaded with MULT_CYCLES.
- div/divu: LO←quotient, HI←remainder, truncating toward zero, remainder takes dividend sign; counter loaded with DIV_CYCLES.
- Divide by zero: Busy runs the full DIV_CYCLES; HI/LO unchanged.
- mthi/mtlo: single-cycle write of `A` to HI/LO at the issue edge; no Busy.
- mfhi/mflo: pure read through `Result`; no state change.
- Counter: `Busy = (cnt != 0)`. cnt decrements each cycle; on the 1→0 edge, pending values commit to HI/LO.
- Once issued, an operation always completes; Cancel affects only the issue cycle.
- Reset (any time, including mid-operation): HI=0, LO=0, cnt=0, Busy=0, pending regs=0; the in-flight operation is abandoned.

## Timing
- Issue in cycle T → Busy=1 in cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES) → Busy=0 and the new HI/LO are visible from T+N+1.
- The hazard unit stalls on `Busy | (Start & MDOp is MD-class)`. The unit does not combine these internally.
- mthi/mtlo issued in T: the new value is visible on HI/LO (and via mfhi/mflo Result) in T+1.
- Result has zero-cycle latency from HI/LO/MDOp.
- Cancel and Start in the same cycle: no issue, no state change.

## Configuration
- `MDU_MADD_EN` defined: adds madd/maddu/msub/msubu, which are MULT_CYCLES long. They compute {HI,LO} ± the 64-bit signed/unsigned product, with the accumulate taken from HI/LO at the issue edge. The result wraps mod 2^64.
- `MDU_MADD_EN` undefined: those codes are treated as no-op (no issue, Busy stays 0).

## Structure
- Shared constants header `mdu_defs.v` holds the MDOp codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
- The same header holds the default cycle counts, shared with the decoder and hazard unit.
- One sub-module, `mdu_arith`: combinational 64-bit signed/unsigned product, quotient and remainder, plus a div-by-zero flag. The top holds the counter, pending registers and HI/LO.

## Test plan
- mult A=0xFFFFFFFF B=0x2 → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7) B=0x2 → Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7 B=2 → LO=3, HI=1.
- mthi A=0x12345678, mtlo A=0x9ABCDEF0 → next cycle mfhi Result=0x12345678, mflo Result=0x9ABCDEF0; divu by B=0 → 10 Busy cycles, HI/LO still those values.
- mult with Cancel=1 → Busy stays 0, HI/LO unchanged; mthi with Cancel=1 → HI unchanged; Start(div) at Busy cycle 2 of a mult → ignored, mult result committed.
- reset driven low in Busy cycle 3 of a div → Busy=0 and HI=LO=0 asynchronously; after release, mfhi Result=0 and no late commit occurs.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu A=1 B=1 → HI=1, LO=0 after 5 cycles; without the macro the same op → Busy=0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: MDOp operation codes and the
// default Busy durations also used by the decoder and the hazard unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: 64-bit product, quotient and remainder in
// signed or unsigned flavour, plus a divide-by-zero flag. Signed division
// truncates toward zero and the remainder follows the dividend's sign.
module mdu_arith (
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic signed [63:0] a_x;
    logic signed [63:0] b_x;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               neg_a;
    logic               neg_b;
    logic        [31:0] mag_a;
    logic        [31:0] mag_b;
    logic        [31:0] quo_m;
    logic        [31:0] rem_m;

    // Product, and division done on magnitudes with the signs restored after
    always_comb begin
        a_x    = {{32{a[31]}}, a};
        b_x    = {{32{b[31]}}, b};
        prod_s = a_x * b_x;
        prod_u = {32'd0, a} * {32'd0, b};
        prod   = is_signed ? prod_s : prod_u;

        neg_a    = is_signed & a[31];
        neg_b    = is_signed & b[31];
        mag_a    = neg_a ? (32'd0 - a) : a;
        mag_b    = neg_b ? (32'd0 - b) : b;
        div_zero = (b == 32'd0);
        quo_m    = div_zero ? 32'd0 : (mag_a / mag_b);
        rem_m    = div_zero ? 32'd0 : (mag_a % mag_b);
        quo      = (neg_a ^ neg_b) ? (32'd0 - quo_m) : quo_m;
        rem      = neg_a ? (32'd0 - rem_m) : rem_m;
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. Results are
// computed at issue, held in pending registers and committed when the busy
// counter steps 1->0. Optional macro MDU_MADD_EN adds madd/maddu/msub/msubu;
// without it those codes never issue.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        Start,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Result
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q, lo_q, pend_hi, pend_lo;
    logic             pend_wr;

    logic             issue, arith_signed, ld_cnt, nxt_wr, wr_hi, wr_lo;
    logic [CNT_W-1:0] ld_val;
    logic [31:0]      nxt_hi, nxt_lo;
    logic [63:0]      prod;
    logic [31:0]      quo, rem;
    logic             div_zero;

    mdu_arith u_arith (
        .is_signed (arith_signed),
        .a         (A),
        .b         (B),
        .prod      (prod),
        .quo       (quo),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    assign Busy = (cnt != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;

    // Decode MDOp into issue controls and the value to hold as pending
    always_comb begin
        issue        = Start & ~Cancel & ~Busy;
        arith_signed = 1'b0;
        ld_cnt       = 1'b0;
        ld_val       = '0;
        nxt_hi       = prod[63:32];
        nxt_lo       = prod[31:0];
        nxt_wr       = 1'b0;
        wr_hi        = 1'b0;
        wr_lo        = 1'b0;
        case (MDOp)
            OP_MULT, OP_MULTU: begin
                arith_signed = (MDOp == OP_MULT);
                ld_cnt       = issue;
                ld_val       = CNT_W'(MULT_CYCLES);
                nxt_wr       = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                arith_signed = (MDOp == OP_DIV);
                ld_cnt       = issue;
                ld_val       = CNT_W'(DIV_CYCLES);
                nxt_hi       = rem;
                nxt_lo       = quo;
                // Divide by zero still runs the full latency but leaves HI/LO alone
                nxt_wr       = ~div_zero;
            end
            OP_MTHI: wr_hi = issue;
            OP_MTLO: wr_lo = issue;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                arith_signed     = (MDOp == OP_MADD);
                ld_cnt           = issue;
                ld_val           = CNT_W'(MULT_CYCLES);
                {nxt_hi, nxt_lo} = {hi_q, lo_q} + prod;
                nxt_wr           = 1'b1;
            end
            OP_MSUB, OP_MSUBU: begin
                arith_signed     = (MDOp == OP_MSUB);
                ld_cnt           = issue;
                ld_val           = CNT_W'(MULT_CYCLES);
                {nxt_hi, nxt_lo} = {hi_q, lo_q} - prod;
                nxt_wr           = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Busy counter, pending result and HI/LO; moves are only accepted when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (ld_cnt) begin
                cnt     <= ld_val;
                pend_hi <= nxt_hi;
                pend_lo <= nxt_lo;
                pend_wr <= nxt_wr;
            end else if (Busy) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1) && pend_wr) begin
                    hi_q <= pend_hi;
                    lo_q <= pend_lo;
                end
            end
            if (wr_hi) hi_q <= A;
            if (wr_lo) lo_q <= A;
        end
    end

    // Move-from reads are a zero-latency mux onto Result
    always_comb begin
        Result = 32'd0;
        if (MDOp == OP_MFHI) Result = hi_q;
        else if (MDOp == OP_MFLO) Result = lo_q;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Testbench for mdu_unit: directed vector table, multi-cycle corner
// sequences and randomized operations checked against a reference model.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, Start, Cancel;
    logic [31:0] A, B;
    logic [3:0]  MDOp;
    logic        Busy;
    logic [31:0] HI, LO, Result;

    always #5 clk = ~clk;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .Start(Start),
        .Cancel(Cancel), .Busy(Busy), .HI(HI), .LO(LO), .Result(Result)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
        int          busy;
    } vec_t;

    vec_t tbl[7];

    logic [31:0] m_hi, m_lo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: applies one op to m_hi/m_lo and returns expected Busy length
    function automatic int model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p, acc;
        sa  = $signed(a);
        sb  = $signed(b);
        acc = {m_hi, m_lo};
        case (op)
            1: begin p = sa * sb; {m_hi, m_lo} = p; return 5; end
            2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; return 5; end
            3: begin
                if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
                return 10;
            end
            4: begin
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
                return 10;
            end
            7: begin m_hi = a; return 0; end
            8: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
            9:  begin p = sa * sb; {m_hi, m_lo} = acc + p; return 5; end
            10: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = acc + p; return 5; end
            11: begin p = sa * sb; {m_hi, m_lo} = acc - p; return 5; end
            12: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = acc - p; return 5; end
`endif
            default: return 0;
        endcase
    endfunction

    // Issue one op for one cycle, then count Busy cycles (bounded)
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cancel, output int nb);
        @(negedge clk);
        MDOp = op; A = a; B = b; Start = 1'b1; Cancel = cancel;
        @(negedge clk);
        Start = 1'b0; Cancel = 1'b0; MDOp = OP_NONE;
        nb = 0;
        while (Busy && nb < 100) begin
            nb++;
            @(negedge clk);
        end
    endtask

    initial begin
        int nb;
        int exp_nb;
        logic [3:0] op;
        logic [31:0] ra, rb;
        logic rc;
        logic [3:0] ops[10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};

        tbl[0] = '{4'd1, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        tbl[1] = '{4'd2, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 5};
        tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[3] = '{4'd4, 32'h7, 32'h2, 32'h1, 32'h3, 10};
        tbl[4] = '{4'd7, 32'h12345678, 32'h0, 32'h12345678, 32'h3, 0};
        tbl[5] = '{4'd8, 32'h9ABCDEF0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0};
        tbl[6] = '{4'd4, 32'h55, 32'h0, 32'h12345678, 32'h9ABCDEF0, 10};

        reset = 1'b0; Start = 1'b0; Cancel = 1'b0; A = '0; B = '0; MDOp = OP_NONE;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, nb);
            chk($sformatf("vec%0d_busy", i), nb, tbl[i].busy);
            chk($sformatf("vec%0d_hi", i), HI, tbl[i].hi);
            chk($sformatf("vec%0d_lo", i), LO, tbl[i].lo);
        end

        // Move-from reads through Result, and zero for other codes
        MDOp = OP_MFHI; #1 chk("mfhi_result", Result, 32'h12345678);
        MDOp = OP_MFLO; #1 chk("mflo_result", Result, 32'h9ABCDEF0);
        MDOp = OP_MULT; #1 chk("result_other", Result, 32'd0);
        MDOp = OP_NONE;

        // Cancel suppresses issue
        run_op(OP_MULT, 32'h3, 32'h4, 1'b1, nb);
        chk("cancel_mult_busy", nb, 0);
        chk("cancel_mult_hi", HI, 32'h12345678);
        chk("cancel_mult_lo", LO, 32'h9ABCDEF0);
        run_op(OP_MTHI, 32'hDEADBEEF, 32'h0, 1'b1, nb);
        chk("cancel_mthi_hi", HI, 32'h12345678);

        // Start(div) during busy cycle 2 of a mult is ignored
        @(negedge clk);
        MDOp = OP_MULT; A = 32'd3; B = 32'd4; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; MDOp = OP_NONE;
        @(negedge clk);
        MDOp = OP_DIV; A = 32'd100; B = 32'd7; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; MDOp = OP_NONE;
        nb = 2;
        while (Busy && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        chk("overlap_busy", nb, 5);
        chk("overlap_hi", HI, 32'd0);
        chk("overlap_lo", LO, 32'd12);

        // Multiply-accumulate codes
        run_op(OP_MTHI, 32'h0, 32'h0, 1'b0, nb);
        run_op(OP_MTLO, 32'hFFFFFFFF, 32'h0, 1'b0, nb);
        run_op(OP_MADDU, 32'h1, 32'h1, 1'b0, nb);
`ifdef MDU_MADD_EN
        chk("maddu_busy", nb, 5);
        chk("maddu_hi", HI, 32'h1);
        chk("maddu_lo", LO, 32'h0);
`else
        chk("maddu_busy", nb, 0);
        chk("maddu_hi", HI, 32'h0);
        chk("maddu_lo", LO, 32'hFFFFFFFF);
`endif

        // Randomized ops against the model
        m_hi = 32'hA5A5A5A5; m_lo = 32'h5A5A5A5A;
        run_op(OP_MTHI, m_hi, 32'h0, 1'b0, nb);
        run_op(OP_MTLO, m_lo, 32'h0, 1'b0, nb);
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 9)];
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            rc = ($urandom_range(0, 7) == 0);
            exp_nb = rc ? 0 : model_op(op, ra, rb);
            run_op(op, ra, rb, rc, nb);
            chk($sformatf("rnd%0d_op%0d_busy", i, op), nb, exp_nb);
            chk($sformatf("rnd%0d_op%0d_hi", i, op), HI, m_hi);
            chk($sformatf("rnd%0d_op%0d_lo", i, op), LO, m_lo);
        end

        // Asynchronous reset in busy cycle 3 of a div
        run_op(OP_MTHI, 32'h11111111, 32'h0, 1'b0, nb);
        run_op(OP_MTLO, 32'h22222222, 32'h0, 1'b0, nb);
        @(negedge clk);
        MDOp = OP_DIV; A = 32'd100; B = 32'd7; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; MDOp = OP_NONE;
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", {31'd0, Busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_busy", {31'd0, Busy}, 32'd0);
        chk("async_reset_hi", HI, 32'd0);
        chk("async_reset_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        MDOp = OP_MFHI; #1 chk("post_reset_mfhi", Result, 32'd0);
        MDOp = OP_NONE;
        repeat (15) @(negedge clk);
        chk("no_late_commit_busy", {31'd0, Busy}, 32'd0);
        chk("no_late_commit_hi", HI, 32'd0);
        chk("no_late_commit_lo", LO, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
